// File: rtl/biquad_pkg.sv
// Shared types and arithmetic helpers for the TDM biquad cascade.
package biquad_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_OUT  = 2'd3
  } fsm_state_e;

  localparam int          COEF_FRAC_DEF = 16;
  localparam logic [23:0] COEF_ONE      = 24'(1) << COEF_FRAC_DEF;

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int frac);
    return (v + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/biquad_mac_unit.sv
// Shared multiply-accumulate for all biquad taps; the accumulator register feeds
// a combinational round-half-up and saturate stage, with a pulse when clamping occurs.
module biquad_mac_unit
  import biquad_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COEF_WIDTH   = 24,
  parameter int COEF_FRAC    = 16,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + COEF_WIDTH + 3
) (
  input  logic                           sample_clock,
  input  logic                           reset,
  input  logic                           i_en,
  input  logic                           i_clear,
  input  logic                           i_neg,
  input  logic signed [COEF_WIDTH-1:0]   i_coef,
  input  logic signed [SAMPLE_WIDTH-1:0] i_data,
  output logic signed [SAMPLE_WIDTH-1:0] o_y,
  output logic                           o_sat
);

  logic signed [SAMPLE_WIDTH+COEF_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]               w_term;
  logic signed [ACC_WIDTH-1:0]               r_acc;
  logic signed [63:0]                        w_rnd;
  logic signed [63:0]                        w_clamp;

  assign w_prod = (SAMPLE_WIDTH+COEF_WIDTH)'(i_coef) * (SAMPLE_WIDTH+COEF_WIDTH)'(i_data);
  assign w_term = i_neg ? -ACC_WIDTH'(w_prod) : ACC_WIDTH'(w_prod);

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= (i_clear ? '0 : r_acc) + w_term;
    end
  end

  assign w_rnd   = round_half_up(64'(r_acc), COEF_FRAC);
  assign w_clamp = sat_clamp(w_rnd, SAMPLE_WIDTH);
  assign o_y     = SAMPLE_WIDTH'(w_clamp);
  assign o_sat   = (w_clamp != w_rnd);

endmodule

// File: rtl/biquad_cascade_tdm.sv
// Cascade of DF1 biquads sharing one MAC: 5 taps + 1 writeback cycle per active stage,
// 1 cycle per bypassed stage; one sample in flight, output held until out_ready.
module biquad_cascade_tdm
  import biquad_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COEF_WIDTH   = 24,
  parameter int COEF_FRAC    = 16,
  parameter int NUM_STAGES   = 4,
  parameter int ACC_WIDTH    = SAMPLE_WIDTH + COEF_WIDTH + 3,
  localparam int STG_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                           sample_clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic [NUM_STAGES-1:0]          bypass,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  input  logic                           coef_we,
  input  logic [STG_W-1:0]               coef_stage,
  input  logic [2:0]                     coef_sel,
  input  logic signed [COEF_WIDTH-1:0]   coef_data,
  input  logic                           clear_state,
  output logic                           sat_flag,
  output logic                           coef_err
);

  localparam logic signed [COEF_WIDTH-1:0] LP_ONE = COEF_WIDTH'(1) << COEF_FRAC;

  fsm_state_e                     r_state;
  logic [STG_W-1:0]               r_stage;
  logic [2:0]                     r_tap;
  logic signed [SAMPLE_WIDTH-1:0] r_x;
  logic [NUM_STAGES-1:0]          r_byp;
  logic signed [COEF_WIDTH-1:0]   r_coef [NUM_STAGES][5];
  logic signed [SAMPLE_WIDTH-1:0] r_x1 [NUM_STAGES];
  logic signed [SAMPLE_WIDTH-1:0] r_x2 [NUM_STAGES];
  logic signed [SAMPLE_WIDTH-1:0] r_y1 [NUM_STAGES];
  logic signed [SAMPLE_WIDTH-1:0] r_y2 [NUM_STAGES];
  logic                           r_out_vld;
  logic signed [SAMPLE_WIDTH-1:0] r_sample_out;
  logic                           r_sat_flag;
  logic                           r_coef_err;

  logic signed [COEF_WIDTH-1:0]   w_mac_coef;
  logic signed [SAMPLE_WIDTH-1:0] w_mac_data;
  logic signed [SAMPLE_WIDTH-1:0] w_y;
  logic signed [SAMPLE_WIDTH-1:0] w_stage_y;
  logic                           w_sat;
  logic                           w_last;
  logic [STG_W-1:0]               w_next_stage;

  assign w_mac_coef   = r_coef[r_stage][r_tap];
  assign w_last       = (r_stage == STG_W'(NUM_STAGES - 1));
  assign w_next_stage = r_stage + STG_W'(1);
  assign w_stage_y    = r_byp[r_stage] ? r_x : w_y;

  always_comb begin
    w_mac_data = r_x;
    case (r_tap)
      3'd1:    w_mac_data = r_x1[r_stage];
      3'd2:    w_mac_data = r_x2[r_stage];
      3'd3:    w_mac_data = r_y1[r_stage];
      3'd4:    w_mac_data = r_y2[r_stage];
      default: w_mac_data = r_x;
    endcase
  end

  // Feedback taps (a1, a2) are subtracted, matching the DF1 difference equation.
  biquad_mac_unit #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .COEF_WIDTH  (COEF_WIDTH),
    .COEF_FRAC   (COEF_FRAC),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .sample_clock(sample_clock),
    .reset       (reset),
    .i_en        (r_state == S_MAC),
    .i_clear     (r_tap == 3'd0),
    .i_neg       (r_tap >= 3'd3),
    .i_coef      (w_mac_coef),
    .i_data      (w_mac_data),
    .o_y         (w_y),
    .o_sat       (w_sat)
  );

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_stage      <= '0;
      r_tap        <= '0;
      r_x          <= '0;
      r_byp        <= '0;
      r_out_vld    <= 1'b0;
      r_sample_out <= '0;
      r_sat_flag   <= 1'b0;
      r_coef_err   <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
        for (int t = 0; t < 5; t++) r_coef[s][t] <= (t == 0) ? LP_ONE : '0;
      end
    end else begin
      if (coef_we && r_state != S_IDLE) r_coef_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (coef_we && coef_sel <= 3'd4 && int'(coef_stage) < NUM_STAGES)
            r_coef[coef_stage][coef_sel] <= coef_data;
          if (clear_state) begin
            r_sat_flag <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
              r_x1[s] <= '0;
              r_x2[s] <= '0;
              r_y1[s] <= '0;
              r_y2[s] <= '0;
            end
          end
          if (in_valid) begin
            r_x     <= sample_in;
            r_byp   <= bypass;
            r_stage <= '0;
            r_tap   <= '0;
            r_state <= bypass[0] ? S_WB : S_MAC;
          end
        end
        S_MAC: begin
          r_tap <= r_tap + 3'd1;
          if (r_tap == 3'd4) r_state <= S_WB;
        end
        S_WB: begin
          if (!r_byp[r_stage]) begin
            r_x2[r_stage] <= r_x1[r_stage];
            r_x1[r_stage] <= r_x;
            r_y2[r_stage] <= r_y1[r_stage];
            r_y1[r_stage] <= w_y;
            r_x           <= w_y;
            if (w_sat) r_sat_flag <= 1'b1;
          end
          if (w_last) begin
            r_sample_out <= w_stage_y;
            r_out_vld    <= 1'b1;
            r_state      <= S_OUT;
          end else begin
            r_stage <= w_next_stage;
            r_tap   <= '0;
            r_state <= r_byp[w_next_stage] ? S_WB : S_MAC;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign out_valid  = r_out_vld;
  assign sample_out = r_sample_out;
  assign sat_flag   = r_sat_flag;
  assign coef_err   = r_coef_err;

endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// Scoreboard bench for biquad_cascade_tdm: directed samples with hand-computed results.
module tb_biquad_cascade_tdm;
  import biquad_pkg::*;

  logic               sample_clock = 1'b0;
  logic               reset        = 1'b1;
  logic               in_valid     = 1'b0;
  logic               in_ready;
  logic signed [23:0] sample_in    = '0;
  logic [3:0]         bypass       = '0;
  logic               out_valid;
  logic               out_ready    = 1'b1;
  logic signed [23:0] sample_out;
  logic               coef_we      = 1'b0;
  logic [1:0]         coef_stage   = '0;
  logic [2:0]         coef_sel     = '0;
  logic signed [23:0] coef_data    = '0;
  logic               clear_state  = 1'b0;
  logic               sat_flag;
  logic               coef_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic signed [63:0] q[$];

  biquad_cascade_tdm #(
    .SAMPLE_WIDTH(24), .COEF_WIDTH(24), .COEF_FRAC(16), .NUM_STAGES(4)
  ) dut (
    .sample_clock(sample_clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .sample_in(sample_in), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .sample_out(sample_out),
    .coef_we(coef_we), .coef_stage(coef_stage), .coef_sel(coef_sel), .coef_data(coef_data),
    .clear_state(clear_state), .sat_flag(sat_flag), .coef_err(coef_err)
  );

  always #5 sample_clock = ~sample_clock;

  initial forever begin
    @(posedge sample_clock);
    cyc++;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is matched against the oldest expected sample.
  initial forever begin
    @(negedge sample_clock);
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'(sample_out), 64'sd0);
        total--;
        check("sb_underflow", 64'(q.size()), 64'sd1);
      end else begin
        check("sample_out", 64'(sample_out), q.pop_front());
      end
    end
  end

  task automatic wcoef(input int stg, input coef_sel_e sel, input logic signed [23:0] d);
    @(posedge sample_clock); #1;
    coef_we = 1'b1; coef_stage = 2'(stg); coef_sel = sel; coef_data = d;
    @(posedge sample_clock); #1;
    coef_we = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge sample_clock); #1;
    clear_state = 1'b1;
    @(posedge sample_clock); #1;
    clear_state = 1'b0;
  endtask

  task automatic send(input logic signed [23:0] x, input logic [3:0] byp,
                      input logic we, input int wstg, input logic signed [23:0] wdat);
    int n = 0;
    @(posedge sample_clock); #1;
    in_valid = 1'b1; sample_in = x; bypass = byp;
    while (!in_ready && n < 200) begin
      @(posedge sample_clock); #1;
      n++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'sd1);
    coef_we = we; coef_stage = 2'(wstg); coef_sel = B0; coef_data = wdat;
    @(posedge sample_clock); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int n = 0;
    do begin
      @(posedge sample_clock); #1;
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) check("out_valid_wait", 64'(out_valid), 64'sd1);
    check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
  endtask

  function automatic int lat_of(input logic [3:0] byp);
    int l = 0;
    for (int i = 0; i < 4; i++) l += byp[i] ? 1 : 6;
    return l;
  endfunction

  task automatic run(input logic signed [23:0] x, input logic [3:0] byp,
                     input logic signed [63:0] exp);
    q.push_back(exp);
    send(x, byp, 1'b0, 0, '0);
    wait_out(lat_of(byp));
  endtask

  initial begin
    repeat (3) @(posedge sample_clock);
    #1;
    check("in_ready_in_reset", 64'(in_ready), 64'sd0);
    reset = 1'b0;
    @(posedge sample_clock); #1;
    check("rst_out_valid", 64'(out_valid), 64'sd0);
    check("rst_sample_out", 64'(sample_out), 64'sd0);
    check("rst_sat_flag", 64'(sat_flag), 64'sd0);
    check("rst_coef_err", 64'(coef_err), 64'sd0);
    check("rst_in_ready", 64'(in_ready), 64'sd1);

    // Passthrough after reset
    run(24'sd1000, 4'b0000, 64'sd1000);

    // Half gain, round-half-up
    wcoef(0, B0, 24'sh008000);
    run(24'sd1001, 4'b0000, 64'sd501);
    run(-24'sd1001, 4'b0000, -64'sd500);

    // One-pole recursion y = x + 0.5*y1
    wcoef(0, B0, 24'sh010000);
    wcoef(0, A1, 24'shFF8000);
    pulse_clear();
    run(24'sd65536, 4'b0000, 64'sd65536);
    run(24'sd0, 4'b0000, 64'sd32768);
    run(24'sd0, 4'b0000, 64'sd16384);
    run(24'sd0, 4'b0000, 64'sd8192);
    wcoef(0, A1, 24'sh000000);

    // Saturation at both rails, sticky flag and its clear
    wcoef(0, B0, 24'sh7F0000);
    run(24'sh7FFFFF, 4'b0000, 64'sd8388607);
    check("sat_flag_set", 64'(sat_flag), 64'sd1);
    run(-24'sd8388608, 4'b0000, -64'sd8388608);
    pulse_clear();
    check("sat_flag_clear", 64'(sat_flag), 64'sd0);
    wcoef(0, B0, 24'sh010000);

    // Output stall: held stable, no new sample accepted
    out_ready = 1'b0;
    q.push_back(64'sd77);
    send(24'sd77, 4'b0000, 1'b0, 0, '0);
    wait_out(24);
    for (int i = 0; i < 10; i++) begin
      @(posedge sample_clock); #1;
      check("stall_out_valid", 64'(out_valid), 64'sd1);
      check("stall_sample_out", 64'(sample_out), 64'sd77);
      check("stall_in_ready", 64'(in_ready), 64'sd0);
    end
    out_ready = 1'b1;

    // Bypass patterns
    run(-24'sd5, 4'b1111, -64'sd5);
    wcoef(0, B0, 24'sh008000);
    run(24'sd1001, 4'b0001, 64'sd1001);
    run(24'sd1001, 4'b0010, 64'sd501);

    // Coef write in the same cycle as the sample: stage1 halves too -> 1001 -> 501 -> 251
    q.push_back(64'sd251);
    send(24'sd1001, 4'b0000, 1'b1, 1, 24'sh008000);
    wait_out(24);
    check("coef_err_same_cycle", 64'(coef_err), 64'sd0);
    wcoef(0, B0, 24'sh010000);
    wcoef(1, B0, 24'sh010000);

    // Coef write mid-MAC is dropped and flagged
    q.push_back(64'sd300);
    send(24'sd300, 4'b0000, 1'b0, 0, '0);
    coef_we = 1'b1; coef_stage = 2'd0; coef_sel = B0; coef_data = 24'sh008000;
    @(posedge sample_clock); #1;
    coef_we = 1'b0;
    check("coef_err_midmac", 64'(coef_err), 64'sd1);
    wait_out(24);
    run(24'sd300, 4'b0000, 64'sd300);

    // Reset mid-MAC abandons the sample and restores passthrough
    wcoef(0, B0, 24'sh008000);
    wcoef(2, A1, 24'sh001234);
    send(24'sd999, 4'b0000, 1'b0, 0, '0);
    repeat (3) begin
      @(posedge sample_clock); #1;
    end
    reset = 1'b1;
    #1;
    check("in_ready_reset_midmac", 64'(in_ready), 64'sd0);
    @(posedge sample_clock); #1;
    check("midrst_out_valid", 64'(out_valid), 64'sd0);
    check("midrst_sample_out", 64'(sample_out), 64'sd0);
    check("midrst_coef_err", 64'(coef_err), 64'sd0);
    check("midrst_sat_flag", 64'(sat_flag), 64'sd0);
    reset = 1'b0;
    run(24'sd1000, 4'b0000, 64'sd1000);

    repeat (4) @(posedge sample_clock);
    #1;
    check("sb_empty", 64'(q.size()), 64'sd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
